// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd_core requester: FSM states,
// default widths/limits and the response record.
package gcd_pkg;

    localparam int GCD_DATA_W  = 8;
    localparam int GCD_TIMEOUT = 300;
    localparam int GCD_CYC_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        WAIT,
        RESP
    } gcd_req_state_t;

    typedef struct packed {
        logic [GCD_DATA_W-1:0] gcd;
        logic                  err;
        logic [GCD_CYC_W-1:0]  cycles;
    } gcd_rsp_t;

endpackage

// File: rtl/gcd_wait_timer.sv
// Clearable saturating up-counter; `last` flags the final count before LIMIT,
// so the owner can act in the same cycle the limit would be reached.
module gcd_wait_timer #(
    parameter int CYC_W = 9,
    parameter int LIMIT = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CYC_W-1:0] count,
    output logic             last
);

    localparam logic [CYC_W-1:0] LIMIT_C   = CYC_W'(LIMIT);
    localparam logic [CYC_W-1:0] LIMIT_M1  = CYC_W'(LIMIT - 1);

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && count != LIMIT_C) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LIMIT_M1);

endmodule

// File: rtl/gcd_requester.sv
// Initiator for gcd_core: takes an (X, Y) request, loads the core over two
// cycles, waits for done (bounded by TIMEOUT) and returns a held response.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int DATA_W  = GCD_DATA_W,
    parameter int TIMEOUT = GCD_TIMEOUT,
    parameter int CYC_W   = GCD_CYC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_x,
    input  logic [DATA_W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_gcd,
    output logic              rsp_err,
    output logic [CYC_W-1:0]  rsp_cycles,
    output logic              core_load,
    output logic [DATA_W-1:0] core_din,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_rslt
);

    gcd_req_state_t    state;
    logic [DATA_W-1:0] y_q;
    logic [CYC_W-1:0]  wait_count;
    logic              wait_last;

    gcd_wait_timer #(
        .CYC_W (CYC_W),
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state == LOAD_Y),
        .en    (state == WAIT),
        .count (wait_count),
        .last  (wait_last)
    );

    // Outputs are registered: each branch sets the values the next state shows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_gcd    <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
            core_load  <= 1'b0;
            core_din   <= '0;
            y_q        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        y_q       <= req_y;
                        if (req_x != '0 && req_y != '0) begin
                            state     <= LOAD_X;
                            core_load <= 1'b1;
                            core_din  <= req_x;
                        end else begin
                            // A zero operand needs no core: gcd(a,0)=a, gcd(0,0) is an error.
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_gcd    <= (req_x != '0) ? req_x : req_y;
                            rsp_err    <= (req_x == '0) && (req_y == '0);
                            rsp_cycles <= '0;
                        end
                    end
                end
                LOAD_X: begin
                    core_din <= y_q;
                    state    <= LOAD_Y;
                end
                LOAD_Y: begin
                    core_load <= 1'b0;
                    core_din  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_gcd    <= core_rslt;
                        rsp_err    <= 1'b0;
                        rsp_cycles <= wait_count + 1'b1;
                        state      <= RESP;
                    end else if (wait_last) begin
                        rsp_valid  <= 1'b1;
                        rsp_gcd    <= '0;
                        rsp_err    <= 1'b1;
                        rsp_cycles <= CYC_W'(TIMEOUT);
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench: two requesters (TIMEOUT 300 and 20), each driving a
// behavioural subtractive gcd_core model that can be made to hang.
module tb_gcd_requester;
    import gcd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, core_load, hang;
    logic [1:0][7:0] req_x, req_y, rsp_gcd, core_din;
    logic [1:0][8:0] rsp_cycles;

    int checks   = 0;
    int failures = 0;
    int load_n   = 0;
    int din_bad  = 0;
    int load_din [64];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int TO = (g == 0) ? 300 : 20;
        logic [7:0] ca, cb;
        logic       busy, phase, done;

        gcd_requester #(.DATA_W(8), .TIMEOUT(TO), .CYC_W(9)) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_x      (req_x[g]),
            .req_y      (req_y[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_gcd    (rsp_gcd[g]),
            .rsp_err    (rsp_err[g]),
            .rsp_cycles (rsp_cycles[g]),
            .core_load  (core_load[g]),
            .core_din   (core_din[g]),
            .core_done  (done),
            .core_rslt  (ca)
        );

        // Core model: X then Y on load, one subtraction per cycle, done as a level.
        always @(posedge clk) begin
            if (rst) begin
                phase <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (core_load[g]) begin
                if (!phase) begin
                    ca    <= core_din[g];
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    phase <= 1'b1;
                end else begin
                    cb    <= core_din[g];
                    busy  <= 1'b1;
                    phase <= 1'b0;
                end
            end else if (busy) begin
                if (ca == cb) begin
                    if (!hang[g]) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end else if (ca > cb) begin
                    ca <= ca - cb;
                end else begin
                    cb <= cb - ca;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (core_load[0]) begin
            if (load_n < 64) load_din[load_n] = int'(core_din[0]);
            load_n++;
        end
        for (int i = 0; i < 2; i++)
            if (!core_load[i] && core_din[i] != 8'd0) din_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int sel, input int limit, output int n);
        n = 0;
        while (!rsp_valid[sel] && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input int sel, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        req_x[sel]     = x;
        req_y[sel]     = y;
        req_valid[sel] = 1'b1;
        while (!req_ready[sel] && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("req_ready_wait", req_ready[sel], 1);
        tick();
        req_valid[sel] = 1'b0;
        req_x[sel]     = 8'hAA;
        req_y[sel]     = 8'h55;
    endtask

    task automatic get_rsp(input int sel, input gcd_rsp_t exp, input string tag);
        int n;
        wait_valid(sel, 400, n);
        check({tag, "_valid"}, rsp_valid[sel], 1);
        check({tag, "_gcd"}, rsp_gcd[sel], exp.gcd);
        check({tag, "_err"}, rsp_err[sel], exp.err);
        check({tag, "_cycles"}, rsp_cycles[sel], exp.cycles);
        rsp_ready[sel] = 1'b1;
        tick();
        rsp_ready[sel] = 1'b0;
        check({tag, "_drop"}, rsp_valid[sel], 0);
    endtask

    initial begin
        int n0;
        int n;
        req_valid = '0;
        rsp_ready = '0;
        hang      = '0;
        req_x     = '0;
        req_y     = '0;
        rst       = 1'b1;
        repeat (2) tick();

        check("rst_req_ready", req_ready[0], 0);
        check("rst_rsp_valid", rsp_valid[0], 0);
        check("rst_rsp_gcd", rsp_gcd[0], 0);
        check("rst_rsp_err", rsp_err[0], 0);
        check("rst_rsp_cycles", rsp_cycles[0], 0);
        check("rst_core_load", core_load[0], 0);
        check("rst_core_din", core_din[0], 0);
        rst = 1'b0;
        tick();
        check("rel_req_ready", req_ready[0], 1);

        // (48,18): two load cycles X then Y, subtractive core needs 4 steps -> 6 cycles
        n0 = load_n;
        send(0, 8'd48, 8'd18);
        check("ld1_load", core_load[0], 1);
        check("ld1_din", core_din[0], 48);
        tick();
        check("ld2_load", core_load[0], 1);
        check("ld2_din", core_din[0], 18);
        tick();
        check("ld3_load", core_load[0], 0);
        check("ld3_din", core_din[0], 0);
        get_rsp(0, '{gcd: 8'd6, err: 1'b0, cycles: 9'd6}, "g48_18");
        check("g48_18_nload", load_n - n0, 2);
        check("g48_18_din0", load_din[n0], 48);
        check("g48_18_din1", load_din[n0 + 1], 18);

        get_rsp_seq();

        // Timeout instance: done never rises; 20 WAIT cycles then RESP
        hang[1] = 1'b1;
        send(1, 8'd12, 8'd8);
        tick();
        wait_valid(1, 100, n);
        check("to_latency", n, 21);
        get_rsp(1, '{gcd: 8'd0, err: 1'b1, cycles: 9'd20}, "timeout");
        hang[1] = 1'b0;
        send(1, 8'd12, 8'd8);
        get_rsp(1, '{gcd: 8'd4, err: 1'b0, cycles: 9'd4}, "g12_8");

        // Backpressure on (9,6)
        send(0, 8'd9, 8'd6);
        wait_valid(0, 100, n);
        check("bp_cycles", rsp_cycles[0], 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp_valid[0], 1);
            check("bp_gcd", rsp_gcd[0], 3);
            check("bp_req_ready", req_ready[0], 0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        check("bp_after_valid", rsp_valid[0], 0);
        check("bp_after_req_ready", req_ready[0], 1);

        // Reset in the middle of WAIT for (100,75)
        send(0, 8'd100, 8'd75);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", rsp_valid[0], 0);
        check("mid_rst_load", core_load[0], 0);
        check("mid_rst_req_ready", req_ready[0], 0);
        check("mid_rst_gcd", rsp_gcd[0], 0);
        rst = 1'b0;
        tick();
        check("mid_rel_req_ready", req_ready[0], 1);
        send(0, 8'd100, 8'd75);
        get_rsp(0, '{gcd: 8'd25, err: 1'b0, cycles: 9'd5}, "g100_75");

        check("din_idle_zero", din_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Equal operands, long subtraction chain, and zero-operand shortcuts.
    task automatic get_rsp_seq();
        int n0;
        send(0, 8'd7, 8'd7);
        get_rsp(0, '{gcd: 8'd7, err: 1'b0, cycles: 9'd2}, "g7_7");
        send(0, 8'd255, 8'd1);
        get_rsp(0, '{gcd: 8'd1, err: 1'b0, cycles: 9'd256}, "g255_1");

        n0 = load_n;
        send(0, 8'd0, 8'd5);
        check("z05_immediate", rsp_valid[0], 1);
        get_rsp(0, '{gcd: 8'd5, err: 1'b0, cycles: 9'd0}, "z0_5");
        send(0, 8'd0, 8'd0);
        get_rsp(0, '{gcd: 8'd0, err: 1'b1, cycles: 9'd0}, "z0_0");
        send(0, 8'd5, 8'd0);
        get_rsp(0, '{gcd: 8'd5, err: 1'b0, cycles: 9'd0}, "z5_0");
        check("zero_no_load", load_n - n0, 0);
    endtask

endmodule
